// File: rtl/mem_controller.sv
// mem_controller: serialises the CPU data port (A) and instruction-fetch port (B)
// onto one asynchronous single-port 16-bit SRAM. Each CPU step is an optional data
// access followed by an instruction fetch; stall holds the pipeline until DONE.
// Optional build macro MEMCTRL_FETCH_BUF_EN adds a one-entry fetch buffer that lets
// a repeated fetch address skip the FETCH phase.
module mem_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [1:0]        a_ctrl,
  input  logic [15:0]       a_wdata,
  output logic [15:0]       a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [15:0]       b_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_dout,
  input  logic [15:0]       ram_din,
  output logic              ram_oe,
  output logic              ram_we_n,
  output logic              ram_ce_n
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DATA_RD    = 3'd1;
  localparam logic [2:0] DATA_WR    = 3'd2;
  localparam logic [2:0] WR_RECOVER = 3'd3;
  localparam logic [2:0] FETCH      = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;

  localparam logic [3:0] LastWait = 4'(WAIT_CYCLES);

  logic [2:0]        state, stateNext;
  logic [3:0]        waitCnt, waitNext;
  logic [ADDR_W-1:0] latBAddr, latBAddrNext;
  logic [15:0]       aRdataNext, bRdataNext;
  logic [ADDR_W-1:0] ramAddrNext, fetchAddr;
  logic [15:0]       ramDoutNext;
  logic              ramOeNext, ramWeNNext, ramCeNNext;
  logic              phaseEnd;

`ifdef MEMCTRL_FETCH_BUF_EN
  logic              bufValid, bufValidNext;
  logic [ADDR_W-1:0] bufAddr, bufAddrNext;
  logic [15:0]       bufData, bufDataNext;
  logic              skipFetch, skipFetchNext;
  logic              bufHit;
`endif

  assign stall    = (state != DONE);
  assign phaseEnd = (waitCnt == LastWait);
  // In IDLE the fetch address is still on the port; afterwards only the latched copy counts.
  assign fetchAddr = (state == IDLE) ? b_addr : latBAddr;

`ifdef MEMCTRL_FETCH_BUF_EN
  assign bufHit = bufValid && (bufAddr == b_addr) && (a_ctrl != 2'b10);
`endif

  // Next-state, result capture and wait counting.
  always_comb begin
    stateNext    = state;
    waitNext     = 4'd0;
    latBAddrNext = latBAddr;
    aRdataNext   = a_rdata;
    bRdataNext   = b_rdata;
`ifdef MEMCTRL_FETCH_BUF_EN
    bufValidNext  = bufValid;
    bufAddrNext   = bufAddr;
    bufDataNext   = bufData;
    skipFetchNext = skipFetch;
`endif
    case (state)
      IDLE: begin
        latBAddrNext = b_addr;
`ifdef MEMCTRL_FETCH_BUF_EN
        skipFetchNext = bufHit;
        if (bufHit) bRdataNext = bufData;
`endif
        if (a_ctrl == 2'b01) begin
          stateNext = DATA_RD;
        end else if (a_ctrl == 2'b10) begin
          stateNext = DATA_WR;
`ifdef MEMCTRL_FETCH_BUF_EN
        end else if (bufHit) begin
          stateNext = DONE;
`endif
        end else begin
          stateNext = FETCH;
        end
      end
      DATA_RD: begin
        if (phaseEnd) begin
          aRdataNext = ram_din;
`ifdef MEMCTRL_FETCH_BUF_EN
          stateNext = skipFetch ? DONE : FETCH;
`else
          stateNext = FETCH;
`endif
        end else begin
          waitNext = waitCnt + 4'd1;
        end
      end
      DATA_WR: begin
`ifdef MEMCTRL_FETCH_BUF_EN
        bufValidNext = 1'b0;
`endif
        if (phaseEnd) stateNext = WR_RECOVER;
        else          waitNext  = waitCnt + 4'd1;
      end
      WR_RECOVER: stateNext = FETCH;
      FETCH: begin
        if (phaseEnd) begin
          bRdataNext = ram_din;
          stateNext  = DONE;
`ifdef MEMCTRL_FETCH_BUF_EN
          bufValidNext = 1'b1;
          bufAddrNext  = latBAddr;
          bufDataNext  = ram_din;
`endif
        end else begin
          waitNext = waitCnt + 4'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // SRAM pins are registered and take the values of the phase being entered.
  always_comb begin
    ramAddrNext = ram_addr;
    ramDoutNext = ram_dout;
    ramOeNext   = 1'b0;
    ramWeNNext  = 1'b1;
    ramCeNNext  = 1'b1;
    case (stateNext)
      DATA_RD: begin
        if (state == IDLE) ramAddrNext = a_addr;
        ramCeNNext = 1'b0;
      end
      DATA_WR: begin
        if (state == IDLE) begin
          ramAddrNext = a_addr;
          ramDoutNext = a_wdata;
        end
        ramOeNext  = 1'b1;
        ramWeNNext = 1'b0;
        ramCeNNext = 1'b0;
      end
      WR_RECOVER: begin
        // Address and data held one cycle after the write strobe rises.
        ramOeNext  = 1'b1;
        ramCeNNext = 1'b0;
      end
      FETCH: begin
        ramAddrNext = fetchAddr;
        ramCeNNext  = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      waitCnt  <= 4'd0;
      latBAddr <= '0;
      a_rdata  <= 16'h0000;
      b_rdata  <= 16'h0000;
      ram_addr <= '0;
      ram_dout <= 16'h0000;
      ram_oe   <= 1'b0;
      ram_we_n <= 1'b1;
      ram_ce_n <= 1'b1;
    end else begin
      state    <= stateNext;
      waitCnt  <= waitNext;
      latBAddr <= latBAddrNext;
      a_rdata  <= aRdataNext;
      b_rdata  <= bRdataNext;
      ram_addr <= ramAddrNext;
      ram_dout <= ramDoutNext;
      ram_oe   <= ramOeNext;
      ram_we_n <= ramWeNNext;
      ram_ce_n <= ramCeNNext;
    end
  end

`ifdef MEMCTRL_FETCH_BUF_EN
  // Fetch buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufValid  <= 1'b0;
      bufAddr   <= '0;
      bufData   <= 16'h0000;
      skipFetch <= 1'b0;
    end else begin
      bufValid  <= bufValidNext;
      bufAddr   <= bufAddrNext;
      bufData   <= bufDataNext;
      skipFetch <= skipFetchNext;
    end
  end
`endif

endmodule
